pipeline_stage_register: RTL and testbench
==========================================

// Module: pipeline_stage_register
// PURPOSE
//   Generic valid/ready inter-stage pipeline register for the 5-stage MIPS core.
//   It replaces the hand-written, per-stage field registers such as ID/EX and EX/MEM.
//   Each stage packs its control word (ctrl) and datapath word (data) into two buses.
//   Stall, flush/bubble insertion and back-pressure are handled here, together with
//   per-stage stall/squash performance counters.
// PARAMETERS
//   DATA_WIDTH   128  datapath payload bits: pc+4, operands, immediate, etc.
//   CTRL_WIDTH   16   control payload bits; zeroed on flush, so all-zero = NOP
//   COUNT_WIDTH  16   width of each saturating performance counter
// PORTS
//   clock          in   1           rising-edge clock
//   reset          in   1           asynchronous, active-high
//   in_valid       in   1           upstream stage holds a valid instruction
//   in_ready       out  1           register accepts in_* this cycle
//   in_ctrl        in   CTRL_WIDTH  upstream control word
//   in_data        in   DATA_WIDTH  upstream datapath word
//   stall          in   1           hazard unit: refuse new input this cycle
//   flush          in   1           branch/jump resolve: squash all held entries
//   out_valid      out  1           out_* holds a valid instruction
//   out_ready      in   1           downstream stage consumes out_* this cycle
//   out_ctrl       out  CTRL_WIDTH  registered control word; 0 when not valid
//   out_data       out  DATA_WIDTH  registered datapath word
//   occupancy      out  2           number of valid entries held (0..2)
//   stall_cycles   out  COUNT_WIDTH cycles with stall=1, saturating
//   squash_count   out  COUNT_WIDTH flushes that discarded >=1 valid entry, saturating
// BEHAVIOUR
//   - Reset: asynchronous, active-high.
//     All outputs are registered and cleared to 0: valid bits, ctrl, data, counters.
//     Exception: in_ready is combinational and is 1 after reset.
//     Reset during a transfer drops that transfer.
//   - Handshake:
//     - in_fire  = in_valid & in_ready.
//     - out_fire = out_valid & out_ready.
//     - Both are evaluated at the rising clock edge.
//   - Latency: 1 cycle from in_fire to out_valid; throughput 1 per cycle while out_ready=1.
//   - Main entry (default build):
//     - in_ready = !stall & !flush & (!out_valid | out_ready).
//     - On in_fire: out_* <= in_*, out_valid <= 1.
//     - Else on out_fire: out_valid <= 0, out_ctrl <= 0 (bubble); out_data holds.
//     - Else: hold all values.
//   - stall: blocks acceptance only; it does not block out_fire.
//     A stalled register drains and then presents a bubble, as the ID/EX hazard rule needs.
//   - flush: has priority over in_fire and over any hold.
//     - Next cycle: every valid bit = 0 and every ctrl field = 0; data holds.
//     - A simultaneous out_fire still counts as completed downstream.
//   - stall and flush in the same cycle: flush semantics apply; stall_cycles still increments.
//   - occupancy = number of set valid bits. out_ctrl is never nonzero while out_valid=0.
//   - Counters:
//     - stall_cycles: +1 on each clock with stall=1.
//     - squash_count: +1 on each clock with flush=1 and occupancy != 0.
//     - Both saturate at 2**COUNT_WIDTH-1 with no wrap.
//     - Both are cleared only by reset.
// CONFIGURATION
//   Macro PIPE_STAGE_SKID_BUFFER_EN.
//   - Undefined: single entry, occupancy <= 1, and in_ready depends combinationally on out_ready.
//   - Defined: adds a skid entry (skid_valid, skid_ctrl, skid_data).
//     - in_ready = !stall & !flush & !skid_valid, with no combinational path from out_ready.
//     - in_fire while out_valid & !out_ready: the input is written to the skid entry.
//     - out_fire with skid_valid: skid moves to main, and skid_valid <= 0.
//       A simultaneous in_fire in that cycle is impossible because in_ready=0.
//     - out_fire with !skid_valid and in_fire: main <= input.
//     - flush clears both entries.
//     - Ordering is strictly FIFO; occupancy reaches 2.
// TESTING
//   1. Reset mid-stream: hold in_valid=1, in_ctrl=16'h00A5; assert reset at t=3.5 cycles
//      -> out_valid=0, out_ctrl=0, counters=0 immediately; in_ready=1 after release.
//   2. Streaming: 8 transfers, ctrl=1..8, out_ready=1
//      -> out_ctrl=1..8 on consecutive cycles, 1-cycle latency, no gaps.
//   3. Stall: stall=1 for 3 cycles with a held entry and out_ready=1
//      -> entry drains; out_valid=0 and out_ctrl=0 for 2 cycles; stall_cycles=3.
//   4. Flush: flush=1 with occupancy=1, in_valid=1
//      -> input dropped, out_valid=0, out_ctrl=0 next cycle, squash_count=1.
//      Flush again with occupancy=0 -> squash_count stays 1.
//   5. Back-pressure: out_ready=0 for 4 cycles while in_valid=1
//      -> default: accepts 1, occupancy=1. Skid build: accepts 2, occupancy=2, in_ready=0.
//      Release -> FIFO order preserved.
//   6. Saturation: COUNT_WIDTH=4, stall=1 for 20 cycles -> stall_cycles=15, no wrap.

Source files
------------

// File: rtl/pipeline_stage_register.sv
// Valid/ready inter-stage pipeline register with stall, flush and saturating perf counters.
// Define PIPE_STAGE_SKID_BUFFER_EN to add a skid entry that removes the out_ready -> in_ready path.
module pipeline_stage_register #(
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned CTRL_WIDTH  = 16,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_WIDTH-1:0]  in_ctrl,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_WIDTH-1:0]  out_ctrl,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [1:0]             occupancy,
    output logic [COUNT_WIDTH-1:0] stall_cycles,
    output logic [COUNT_WIDTH-1:0] squash_count
);

    localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);

    logic                   mainValid;
    logic [CTRL_WIDTH-1:0]  mainCtrl;
    logic [DATA_WIDTH-1:0]  mainData;
    logic                   skidValid;
    logic                   inFire;
    logic                   outFire;
    logic [COUNT_WIDTH-1:0] stallCount;
    logic [COUNT_WIDTH-1:0] squashCount;

    assign inFire  = in_valid && in_ready;
    assign outFire = mainValid && out_ready;

`ifdef PIPE_STAGE_SKID_BUFFER_EN
    logic [CTRL_WIDTH-1:0] skidCtrl;
    logic [DATA_WIDTH-1:0] skidData;

    assign in_ready = !stall && !flush && !skidValid;

    // The skid entry only ever fills while main is blocked, so it is always the younger entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mainValid <= 1'b0;
            mainCtrl  <= '0;
            mainData  <= '0;
            skidValid <= 1'b0;
            skidCtrl  <= '0;
            skidData  <= '0;
        end else if (flush) begin
            mainValid <= 1'b0;
            mainCtrl  <= '0;
            skidValid <= 1'b0;
            skidCtrl  <= '0;
        end else if (outFire && skidValid) begin
            mainValid <= 1'b1;
            mainCtrl  <= skidCtrl;
            mainData  <= skidData;
            skidValid <= 1'b0;
            skidCtrl  <= '0;
        end else if (inFire && mainValid && !out_ready) begin
            skidValid <= 1'b1;
            skidCtrl  <= in_ctrl;
            skidData  <= in_data;
        end else if (inFire) begin
            mainValid <= 1'b1;
            mainCtrl  <= in_ctrl;
            mainData  <= in_data;
        end else if (outFire) begin
            mainValid <= 1'b0;
            mainCtrl  <= '0;
        end
    end
`else
    assign skidValid = 1'b0;
    assign in_ready  = !stall && !flush && (!mainValid || out_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mainValid <= 1'b0;
            mainCtrl  <= '0;
            mainData  <= '0;
        end else if (flush) begin
            mainValid <= 1'b0;
            mainCtrl  <= '0;
        end else if (inFire) begin
            mainValid <= 1'b1;
            mainCtrl  <= in_ctrl;
            mainData  <= in_data;
        end else if (outFire) begin
            mainValid <= 1'b0;
            mainCtrl  <= '0;
        end
    end
`endif

    assign occupancy = {1'b0, mainValid} + {1'b0, skidValid};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stallCount  <= '0;
            squashCount <= '0;
        end else begin
            if (stall && (stallCount != '1)) begin
                stallCount <= stallCount + CountOne;
            end
            if (flush && (occupancy != 2'd0) && (squashCount != '1)) begin
                squashCount <= squashCount + CountOne;
            end
        end
    end

    assign out_valid    = mainValid;
    assign out_ctrl     = mainCtrl;
    assign out_data     = mainData;
    assign stall_cycles = stallCount;
    assign squash_count = squashCount;

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Self-checking bench for pipeline_stage_register: directed table, corner sequences, random vs queue model.
module tb_pipeline_stage_register;

    localparam int unsigned DW = 128;
    localparam int unsigned CW = 16;
    localparam int unsigned NW = 16;
    localparam int unsigned CountMax = (1 << NW) - 1;
`ifdef PIPE_STAGE_SKID_BUFFER_EN
    localparam int Cap = 2;
`else
    localparam int Cap = 1;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [NW-1:0] stall_cycles;
    logic [NW-1:0] squash_count;

    logic          satStall = 1'b0;
    logic          satInReady;
    logic          satOutValid;
    logic [3:0]    satOutCtrl;
    logic [7:0]    satOutData;
    logic [1:0]    satOccupancy;
    logic [3:0]    satStallCycles;
    logic [3:0]    satSquashCount;

    always #5 clock = ~clock;

    pipeline_stage_register #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .COUNT_WIDTH(NW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .stall_cycles(stall_cycles), .squash_count(squash_count)
    );

    pipeline_stage_register #(.DATA_WIDTH(8), .CTRL_WIDTH(4), .COUNT_WIDTH(4)) dutSat (
        .clock(clock), .reset(reset),
        .in_valid(1'b0), .in_ready(satInReady), .in_ctrl(4'h0), .in_data(8'h00),
        .stall(satStall), .flush(1'b0),
        .out_valid(satOutValid), .out_ready(1'b1), .out_ctrl(satOutCtrl), .out_data(satOutData),
        .occupancy(satOccupancy), .stall_cycles(satStallCycles), .squash_count(satSquashCount)
    );

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        modelQ[$];
    logic [DW-1:0] modelData;
    int unsigned   modelStall;
    int unsigned   modelSquash;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic modelInReady(input logic st, input logic fl, input logic ordy);
        if (st || fl) return 1'b0;
        if (Cap == 2) return modelQ.size() < 2;
        return (modelQ.size() == 0) || ordy;
    endfunction

    task automatic modelClear();
        modelQ.delete();
        modelData   = '0;
        modelStall  = 0;
        modelSquash = 0;
    endtask

    // Abstract behaviour: a FIFO of capacity Cap, head presented on out_*.
    task automatic modelStep();
        logic   acc;
        entry_t e;
        acc = in_valid && modelInReady(stall, flush, out_ready);
        if (stall && modelStall < CountMax) modelStall++;
        if (flush) begin
            if (modelQ.size() > 0 && modelSquash < CountMax) modelSquash++;
            modelQ.delete();
        end else begin
            if (out_ready && modelQ.size() > 0) void'(modelQ.pop_front());
            if (acc) begin
                e.ctrl = in_ctrl;
                e.data = in_data;
                modelQ.push_back(e);
            end
        end
        if (modelQ.size() > 0) modelData = modelQ[0].data;
    endtask

    task automatic modelCheck();
        logic [CW-1:0] expCtrl;
        expCtrl = (modelQ.size() > 0) ? modelQ[0].ctrl : '0;
        check("rand out_valid", 128'(out_valid), 128'(modelQ.size() > 0));
        check("rand out_ctrl", 128'(out_ctrl), 128'(expCtrl));
        check("rand out_data", 128'(out_data), 128'(modelData));
        check("rand occupancy", 128'(occupancy), 128'(modelQ.size()));
        check("rand stall_cycles", 128'(stall_cycles), 128'(modelStall));
        check("rand squash_count", 128'(squash_count), 128'(modelSquash));
    endtask

    task automatic cycle();
        @(posedge clock);
        modelStep();
        @(negedge clock);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset     = 1'b1;
        in_valid  = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        satStall  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        modelClear();
        @(negedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        logic          iv;
        logic          st;
        logic          fl;
        logic [CW-1:0] ctrl;
        logic          ir;
        logic          ov;
        logic [CW-1:0] oc;
        logic [1:0]    occ;
        int unsigned   sc;
        int unsigned   sq;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int accepted;
        logic irSample;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b1, 16'h0001, 2'd1, 0, 0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b1, 16'h0002, 2'd1, 0, 0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, 16'h0000, 2'd0, 1, 0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, 16'h0000, 2'd0, 2, 0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b1, 16'h0003, 2'd1, 2, 0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b0, 16'h0000, 2'd0, 2, 1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 16'h0000, 2'd0, 2, 1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 16'h0006, 1'b0, 1'b0, 16'h0000, 2'd0, 3, 1};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 16'h0007, 1'b1, 1'b1, 16'h0007, 2'd1, 3, 1};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 16'h0008, 1'b1, 1'b0, 16'h0000, 2'd0, 3, 1};

        // Reset mid-stream
        doReset();
        check("reset out_valid", 128'(out_valid), 128'(0));
        check("reset in_ready", 128'(in_ready), 128'(1));
        in_valid = 1'b1; in_ctrl = 16'h00A5; in_data = {8{16'h00A5}};
        out_ready = 1'b0; stall = 1'b1;
        cycle();
        stall = 1'b0;
        cycle();
        cycle();
        check("pre-reset out_ctrl", 128'(out_ctrl), 128'(16'h00A5));
        check("pre-reset stall_cycles", 128'(stall_cycles), 128'(1));
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("async reset out_valid", 128'(out_valid), 128'(0));
        check("async reset out_ctrl", 128'(out_ctrl), 128'(0));
        check("async reset out_data", 128'(out_data), 128'(0));
        check("async reset occupancy", 128'(occupancy), 128'(0));
        check("async reset stall_cycles", 128'(stall_cycles), 128'(0));
        @(negedge clock);
        reset = 1'b0;
        modelClear();
        #1;
        check("post-reset in_ready", 128'(in_ready), 128'(1));

        // Directed table: streaming, stall drain, flush and counter rules
        doReset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = vecs[i].iv; stall = vecs[i].st; flush = vecs[i].fl;
            in_ctrl = vecs[i].ctrl; in_data = {8{vecs[i].ctrl}};
            #1;
            check($sformatf("vec%0d in_ready", i), 128'(in_ready), 128'(vecs[i].ir));
            cycle();
            check($sformatf("vec%0d out_valid", i), 128'(out_valid), 128'(vecs[i].ov));
            check($sformatf("vec%0d out_ctrl", i), 128'(out_ctrl), 128'(vecs[i].oc));
            check($sformatf("vec%0d occupancy", i), 128'(occupancy), 128'(vecs[i].occ));
            check($sformatf("vec%0d stall_cycles", i), 128'(stall_cycles), 128'(vecs[i].sc));
            check($sformatf("vec%0d squash_count", i), 128'(squash_count), 128'(vecs[i].sq));
        end

        // Streaming 8 transfers back to back
        doReset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_ctrl = CW'(k); in_data = {4{32'(k * 7)}};
            #1;
            check("stream in_ready", 128'(in_ready), 128'(1));
            cycle();
            check("stream out_valid", 128'(out_valid), 128'(1));
            check("stream out_ctrl", 128'(out_ctrl), 128'(k));
            check("stream out_data", 128'(out_data), {4{32'(k * 7)}});
        end
        in_valid = 1'b0;
        cycle();
        check("stream end out_valid", 128'(out_valid), 128'(0));

        // Stall drains a held entry, then bubbles
        doReset();
        in_valid = 1'b1; in_ctrl = 16'h0033; in_data = '1; out_ready = 1'b0;
        cycle();
        check("stall preload occupancy", 128'(occupancy), 128'(1));
        in_ctrl = 16'h0044; stall = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall out_valid", 128'(out_valid), 128'(0));
            check("stall out_ctrl", 128'(out_ctrl), 128'(0));
            check("stall out_data holds", 128'(out_data), '1);
        end
        check("stall stall_cycles", 128'(stall_cycles), 128'(3));
        stall = 1'b0; in_valid = 1'b0;

        // Back-pressure then release in FIFO order
        doReset();
        out_ready = 1'b0; in_valid = 1'b1; accepted = 0;
        for (int k = 0; k < 4; k++) begin
            in_ctrl = CW'(16'h0050 + accepted); in_data = DW'(accepted);
            #1;
            irSample = in_ready;
            cycle();
            if (irSample) accepted++;
        end
        check("bp accepted", 128'(accepted), 128'(Cap));
        check("bp occupancy", 128'(occupancy), 128'(Cap));
        check("bp in_ready", 128'(in_ready), 128'(0));
        check("bp head ctrl", 128'(out_ctrl), 128'(16'h0050));
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < Cap; i++) begin
            cycle();
            check("bp release out_valid", 128'(out_valid), 128'(i + 1 < Cap));
            check("bp release out_ctrl", 128'(out_ctrl), 128'((i + 1 < Cap) ? 16'h0051 + i : 0));
        end

        // Random traffic against the queue model
        doReset();
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(3) != 0);
            stall     = ($urandom_range(7) == 0);
            flush     = ($urandom_range(15) == 0);
            out_ready = ($urandom_range(2) != 0);
            in_ctrl   = CW'($urandom_range(16'hFFFF, 1));
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            #1;
            check("rand in_ready", 128'(in_ready), 128'(modelInReady(stall, flush, out_ready)));
            cycle();
            modelCheck();
        end

        // Counter saturation on a narrow instance
        doReset();
        satStall = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (k == 14 || k == 15 || k == 20)
                check($sformatf("sat stall_cycles@%0d", k), 128'(satStallCycles), 128'((k < 15) ? k : 15));
        end
        check("sat squash_count", 128'(satSquashCount), 128'(0));
        satStall = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
